// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and a constant-evaluable ceil(log2) for sizing the iteration counter.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Operand conditioner: when en is set and the value is negative, returns its magnitude.
// The magnitude of the most negative value (e.g. 0x80 -> 128) still fits as an unsigned WIDTH-bit number.
module mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val,
    input  logic             en,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    assign sign = en & val[WIDTH-1];
    assign mag  = sign ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one WIDTH x WIDTH product in WIDTH iterations,
// start/done handshake, optional two's-complement mode, synchronous clear.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 clear,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   outcome
);

    localparam int                CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_temp_a;
    logic [WIDTH-1:0]      r_temp_b;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg;
    logic                  r_busy;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_outcome;

    state_t                w_state_nxt;
    logic [2*WIDTH-1:0]    w_acc_nxt;
    logic [2*WIDTH-1:0]    w_temp_a_nxt;
    logic [WIDTH-1:0]      w_temp_b_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_neg_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [2*WIDTH-1:0]    w_outcome_nxt;

    logic                  w_signed_eff;
    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic                  w_sign_a;
    logic                  w_sign_b;

    assign w_signed_eff = SIGNED_EN & signed_mode;

    mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val  (a),
        .en   (w_signed_eff),
        .mag  (w_mag_a),
        .sign (w_sign_a)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val  (b),
        .en   (w_signed_eff),
        .mag  (w_mag_b),
        .sign (w_sign_b)
    );

    // Next-state and datapath update; clear overrides everything, illegal encodings fall back to IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_temp_a_nxt  = r_temp_a;
        w_temp_b_nxt  = r_temp_b;
        w_cnt_nxt     = r_cnt;
        w_neg_nxt     = r_neg;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_outcome_nxt = r_outcome;

        if (clear) begin
            w_state_nxt   = ST_IDLE;
            w_busy_nxt    = 1'b0;
            w_outcome_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_temp_a_nxt = {{WIDTH{1'b0}}, w_mag_a};
                        w_temp_b_nxt = w_mag_b;
                        w_neg_nxt    = w_sign_a ^ w_sign_b;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_busy_nxt   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_temp_b[0]) begin
                        w_acc_nxt = r_acc + r_temp_a;
                    end else begin
                        w_acc_nxt = r_acc;
                    end
                    w_temp_a_nxt = r_temp_a << 1;
                    w_temp_b_nxt = r_temp_b >> 1;
                    w_cnt_nxt    = r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FIN: begin
                    w_outcome_nxt = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
                default: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers with asynchronous reset to all-zero / IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_temp_a  <= '0;
            r_temp_b  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_outcome <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_temp_a  <= w_temp_a_nxt;
            r_temp_b  <= w_temp_b_nxt;
            r_cnt     <= w_cnt_nxt;
            r_neg     <= w_neg_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_outcome <= w_outcome_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign outcome = r_outcome;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=8): table of products scored through a queue,
// plus hand sequences for handshake, clear, async reset and the SIGNED_EN=0 build.
module tb_mult_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] exp;
        int             edge_k;
    } sb_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           clear;
    logic           busy;
    logic           done;
    logic [2*W-1:0] outcome;
    logic           us_busy;
    logic           us_done;
    logic [2*W-1:0] us_outcome;

    int   n_checks;
    int   n_errors;
    int   cyc;
    int   done_cnt;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[10];

    mult_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .clear(clear),
        .busy(busy), .done(done), .outcome(outcome)
    );

    mult_seq #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_us (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .clear(clear),
        .busy(us_busy), .done(us_done), .outcome(us_outcome)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse pops one expected product and checks value and latency.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            if (sb_q.size() == 0) begin
                n_checks = n_checks + 1;
                n_errors = n_errors + 1;
                $display("FAIL unexpected_done: outcome=%h, required no done pulse", outcome);
            end else begin
                mon_e = sb_q.pop_front();
                n_checks = n_checks + 2;
                if (outcome !== mon_e.exp) begin
                    n_errors = n_errors + 1;
                    $display("FAIL product: got %h, expected %h", outcome, mon_e.exp);
                end
                if (cyc - mon_e.edge_k != W + 1) begin
                    n_errors = n_errors + 1;
                    $display("FAIL latency: got %0d edges after start edge, expected %0d", cyc - mon_e.edge_k, W + 1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Called just after a negedge; drives start for one edge and returns at the done negedge.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                         input logic [2*W-1:0] texp, output int bcyc);
        bit got;
        a           = ta;
        b           = tb_v;
        signed_mode = tsm;
        start       = 1'b1;
        sb_q.push_back('{texp, cyc + 1});
        bcyc = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcyc = bcyc + 1;
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL op_timeout: no done for %h*%h, expected done within 40 cycles", ta, tb_v);
        end
    endtask

    initial begin
        int bc;
        int dc0;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'h00, 8'h1C, 1'b0, 16'h0000};
        vecs[2] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
        vecs[6] = '{8'h07, 8'hFF, 1'b1, 16'hFFF9};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[8] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
        vecs[9] = '{8'h0C, 8'h0D, 1'b1, 16'h009C};

        repeat (2) @(negedge clk);
        check("reset_outcome", 32'(outcome), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd15, 8'd21, 1'b0, 16'd315, bc);
        check("busy_cycles", 32'(bc), 32'd9);

        // start re-asserted mid-operation with other operands must be ignored
        a = 8'd15; b = 8'd21; signed_mode = 1'b0; start = 1'b1;
        sb_q.push_back('{16'd315, cyc + 1});
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 8'd2; b = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("ignored_start_done", 32'(done), 32'h1);

        // back-to-back: each call starts in the done cycle of the previous one
        @(negedge clk);
        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, bc);
        do_op(8'h00, 8'h1C, 1'b0, 16'h0000, bc);
        do_op(8'd15, 8'd28, 1'b0, 16'h01A4, bc);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, bc);
        end

        do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, bc);
        check("unsigned_build_product", 32'(us_outcome), 32'h04F1);
        check("unsigned_build_done", 32'(us_done), 32'h1);

        // clear during iteration 4 aborts with no done pulse
        @(negedge clk);
        dc0 = done_cnt;
        a = 8'd15; b = 8'd21; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_outcome", 32'(outcome), 32'h0);
        check("clear_busy", 32'(busy), 32'h0);
        check("clear_done", 32'(done), 32'h0);
        repeat (15) @(negedge clk);
        check("clear_no_done", 32'(done_cnt), 32'(dc0));

        // clear and start together: start dropped
        a = 8'd3; b = 8'd3; start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("clear_start_busy", 32'(busy), 32'h0);
        repeat (15) @(negedge clk);
        check("clear_start_no_done", 32'(done_cnt), 32'(dc0));

        // asynchronous reset mid-RUN, between edges
        do_op(8'd15, 8'd21, 1'b0, 16'd315, bc);
        @(negedge clk);
        a = 8'd15; b = 8'd21; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outcome", 32'(outcome), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd15, 8'd28, 1'b0, 16'h01A4, bc);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
